// File: rtl/part_2_trgt_upload_buf.sv
// rtl/part_2_trgt_upload_buf.sv - upload buffer for part 2 target samples with freeze request
//
// Captures one {valid, o_data} sample per synchronised clk_3 strobe and tags it
// with an 8-bit sequence number. Samples are held in a first-word-fall-through
// FIFO and handed to the transport via a valid/ready handshake. A mission-clock
// freeze is requested while the buffer is near full (hysteresis between
// FREEZE_LVL and RELEASE_LVL).
//
// Optional build macro: CS_UPLOAD_CHANGE_ONLY_EN
//   Defined: a sample equal to the last accepted one is skipped. The sequence
//   number still advances, so the receiver sees a gap meaning "unchanged".
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cap_stb_i            one-cycle capture strobe
//   valid_i, o_data_i    sample fields
//   tx_valid_o/tx_data_o/tx_seq_o/tx_ready_i   head-of-FIFO handshake
//   freeze_req_o         freeze request to mission clock 3
//   level_o              FIFO occupancy
//   overflow_o           sticky drop flag
//   drop_cnt_o           saturating drop count
//   clr_ovf_i            clears overflow_o and drop_cnt_o
module part_2_trgt_upload_buf #(
    parameter int DW          = 9,
    parameter int DEPTH       = 8,
    parameter int FREEZE_LVL  = DEPTH - 2,
    parameter int RELEASE_LVL = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cap_stb_i,
    input  logic          valid_i,
    input  logic [7:0]    o_data_i,
    output logic          tx_valid_o,
    output logic [DW-1:0] tx_data_o,
    output logic [7:0]    tx_seq_o,
    input  logic          tx_ready_i,
    output logic          freeze_req_o,
    output logic [AW:0]   level_o,
    output logic          overflow_o,
    output logic [7:0]    drop_cnt_o,
    input  logic          clr_ovf_i
);

    typedef enum logic {RUN, FROZEN} state_e;

    localparam logic [AW:0] FULL_L    = (AW+1)'(DEPTH);
    localparam logic [AW:0] FREEZE_L  = (AW+1)'(FREEZE_LVL);
    localparam logic [AW:0] RELEASE_L = (AW+1)'(RELEASE_LVL);
    localparam logic [AW:0] ONE_L     = (AW+1)'(1);

    logic [DW+7:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    level_q, level_d;
    logic [7:0]     seq_q;
    logic           ovf_q, ovf_d;
    logic [7:0]     drop_q, drop_d;
    state_e         state_q, state_d;

    logic [DW-1:0]  sample_w;
    logic           full_w, pop_w, push_w, drop_w, keep_w;

    assign sample_w = {valid_i, o_data_i};
    assign full_w   = (level_q == FULL_L);
    assign pop_w    = tx_valid_o && tx_ready_i;

`ifdef CS_UPLOAD_CHANGE_ONLY_EN
    // Last accepted sample; last_vld_q forces the first strobe after reset through.
    logic [DW-1:0] last_q;
    logic          last_vld_q;

    assign keep_w = !(last_vld_q && (sample_w == last_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push_w) begin
            last_q     <= sample_w;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign keep_w = 1'b1;
`endif

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push_w = cap_stb_i && keep_w && (!full_w || pop_w);
    assign drop_w = cap_stb_i && keep_w && full_w && !pop_w;

    assign tx_valid_o   = (level_q != '0);
    assign tx_data_o    = tx_valid_o ? mem_q[rd_ptr_q][DW+7:8] : '0;
    assign tx_seq_o     = tx_valid_o ? mem_q[rd_ptr_q][7:0]    : '0;
    assign level_o      = level_q;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;
    assign freeze_req_o = (state_q == FROZEN);

    always_comb begin
        level_d = level_q;
        case ({push_w, pop_w})
            2'b10:   level_d = level_q + ONE_L;
            2'b01:   level_d = level_q - ONE_L;
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as a clear wins and restarts the count at 1.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop_w) begin
            ovf_d  = 1'b1;
            drop_d = clr_ovf_i ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
        end else if (clr_ovf_i) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (level_d >= FREEZE_L)  state_d = FROZEN;
            FROZEN:  if (level_d <= RELEASE_L) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= 8'd0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
            state_q  <= RUN;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (cap_stb_i) seq_q <= seq_q + 8'd1;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            state_q <= state_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_w) mem_q[wr_ptr_q] <= {sample_w, seq_q};
    end

endmodule

// File: tb/tb_part_2_trgt_upload_buf.sv
// tb/tb_part_2_trgt_upload_buf.sv - directed self-checking bench for part_2_trgt_upload_buf
module tb_part_2_trgt_upload_buf;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cap_stb_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] o_data_i = 8'd0;
    logic       tx_ready_i = 1'b0;
    logic       clr_ovf_i = 1'b0;
    logic       tx_valid_o;
    logic [8:0] tx_data_o;
    logic [7:0] tx_seq_o;
    logic       freeze_req_o;
    logic [3:0] level_o;
    logic       overflow_o;
    logic [7:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    part_2_trgt_upload_buf dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cap_stb_i    (cap_stb_i),
        .valid_i      (valid_i),
        .o_data_i     (o_data_i),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_seq_o     (tx_seq_o),
        .tx_ready_i   (tx_ready_i),
        .freeze_req_o (freeze_req_o),
        .level_o      (level_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o),
        .clr_ovf_i    (clr_ovf_i)
    );

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        cap_stb_i = 1'b0; tx_ready_i = 1'b0; clr_ovf_i = 1'b0;
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic set_sample(input logic [8:0] s);
        cap_stb_i = 1'b1;
        valid_i   = s[8];
        o_data_i  = s[7:0];
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tx_valid_o, tx_data_o, tx_seq_o, freeze_req_o, level_o, overflow_o, drop_cnt_o} !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b data=%h seq=%0d frz=%0b lvl=%0d ovf=%0b drop=%0d, want all 0",
                     tx_valid_o, tx_data_o, tx_seq_o, freeze_req_o, level_o, overflow_o, drop_cnt_o);
        end
    endtask

    task automatic test_basic();
        logic [8:0] vals [3];
        vals[0] = 9'h1A5; vals[1] = 9'h0FF; vals[2] = 9'h100;
        do_reset();
        tx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_sample(vals[i]);
            step();
            checks++;
            if (!(tx_valid_o === 1'b1 && tx_data_o === vals[i] && tx_seq_o === 8'(i) && level_o === 4'd1)) begin
                errors++;
                $display("FAIL basic_head%0d: got v=%0b d=%h s=%0d l=%0d, want v=1 d=%h s=%0d l=1",
                         i, tx_valid_o, tx_data_o, tx_seq_o, level_o, vals[i], i);
            end
        end
        cap_stb_i = 1'b0;
        step();
        checks++;
        if (tx_valid_o !== 1'b0 || level_o !== 4'd0) begin
            errors++;
            $display("FAIL basic_drain: got v=%0b l=%0d, want v=0 l=0", tx_valid_o, level_o);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_sample(9'h100 + 9'(i));
            step();
            if (i >= 4) begin
                checks++;
                if (level_o !== 4'(i + 1) || freeze_req_o !== (i == 5)) begin
                    errors++;
                    $display("FAIL freeze_rise%0d: got l=%0d f=%0b, want l=%0d f=%0b",
                             i, level_o, freeze_req_o, i + 1, i == 5);
                end
            end
        end
        cap_stb_i = 1'b0;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (level_o !== 4'(5 - i) || freeze_req_o !== (i != 3)) begin
                errors++;
                $display("FAIL freeze_fall%0d: got l=%0d f=%0b, want l=%0d f=%0b",
                         i, level_o, freeze_req_o, 5 - i, i != 3);
            end
        end
        tx_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_sample(9'h100 + 9'(i));
            step();
        end
        cap_stb_i = 1'b0;
        checks++;
        if (level_o !== 4'd8 || overflow_o !== 1'b1 || drop_cnt_o !== 8'd2 || tx_seq_o !== 8'd0 || tx_data_o !== 9'h100) begin
            errors++;
            $display("FAIL ovf_state: got l=%0d o=%0b dc=%0d s=%0d d=%h, want l=8 o=1 dc=2 s=0 d=100",
                     level_o, overflow_o, drop_cnt_o, tx_seq_o, tx_data_o);
        end
        tx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_seq_o !== 8'(i) || tx_data_o !== 9'h100 + 9'(i)) begin
                errors++;
                $display("FAIL ovf_drain%0d: got s=%0d d=%h, want s=%0d d=%h", i, tx_seq_o, tx_data_o, i, 9'h100 + 9'(i));
            end
            step();
        end
        tx_ready_i = 1'b0;
        set_sample(9'h0AA);
        step();
        cap_stb_i = 1'b0;
        checks++;
        if (tx_seq_o !== 8'd10 || level_o !== 4'd1) begin
            errors++;
            $display("FAIL ovf_next_seq: got s=%0d l=%0d, want s=10 l=1", tx_seq_o, level_o);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_sample(9'(i));
            step();
        end
        set_sample(9'h1FF);
        tx_ready_i = 1'b1;
        step();
        tx_ready_i = 1'b0;
        checks++;
        if (level_o !== 4'd8 || overflow_o !== 1'b0 || drop_cnt_o !== 8'd0 || tx_seq_o !== 8'd1) begin
            errors++;
            $display("FAIL full_pop: got l=%0d o=%0b dc=%0d s=%0d, want l=8 o=0 dc=0 s=1",
                     level_o, overflow_o, drop_cnt_o, tx_seq_o);
        end
        step();
        step();
        clr_ovf_i = 1'b1;
        step();
        checks++;
        if (overflow_o !== 1'b1 || drop_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL clr_vs_drop: got o=%0b dc=%0d, want o=1 dc=1", overflow_o, drop_cnt_o);
        end
        clr_ovf_i = 1'b0;
        step();
        checks++;
        if (drop_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL drop_incr: got dc=%0d, want 2", drop_cnt_o);
        end
        cap_stb_i = 1'b0;
        clr_ovf_i = 1'b1;
        step();
        clr_ovf_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0 || drop_cnt_o !== 8'd0 || level_o !== 4'd8) begin
            errors++;
            $display("FAIL clr_only: got o=%0b dc=%0d l=%0d, want o=0 dc=0 l=8", overflow_o, drop_cnt_o, level_o);
        end
    endtask

    task automatic test_wrap_and_reset();
        int bad = 0;
        do_reset();
        tx_ready_i = 1'b1;
        for (int i = 0; i < 260; i++) begin
            set_sample(9'(i));
            step();
            if (tx_seq_o !== 8'(i) || level_o !== 4'd1) bad++;
        end
        checks++;
        if (bad != 0 || drop_cnt_o !== 8'd0 || tx_seq_o !== 8'd3) begin
            errors++;
            $display("FAIL seq_wrap: got bad=%0d dc=%0d last_s=%0d, want bad=0 dc=0 last_s=3", bad, drop_cnt_o, tx_seq_o);
        end
        tx_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_sample(9'h055);
            step();
        end
        cap_stb_i = 1'b0;
        checks++;
        if (level_o !== 4'd4) begin
            errors++;
            $display("FAIL pre_reset_level: got l=%0d, want 4", level_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (tx_valid_o !== 1'b0 || level_o !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b l=%0d, want v=0 l=0", tx_valid_o, level_o);
        end
        #2;
        rst_ni = 1'b1;
        set_sample(9'h077);
        step();
        cap_stb_i = 1'b0;
        checks++;
        if (tx_seq_o !== 8'd0 || tx_data_o !== 9'h077 || level_o !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_seq: got s=%0d d=%h l=%0d, want s=0 d=077 l=1", tx_seq_o, tx_data_o, level_o);
        end
    endtask

    task automatic test_change_only();
        logic [8:0] vals [3];
        vals[0] = 9'h055; vals[1] = 9'h055; vals[2] = 9'h056;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_sample(vals[i]);
            step();
        end
        cap_stb_i = 1'b0;
`ifdef CS_UPLOAD_CHANGE_ONLY_EN
        checks++;
        if (level_o !== 4'd2 || drop_cnt_o !== 8'd0 || tx_data_o !== 9'h055 || tx_seq_o !== 8'd0) begin
            errors++;
            $display("FAIL chg_first: got l=%0d dc=%0d d=%h s=%0d, want l=2 dc=0 d=055 s=0",
                     level_o, drop_cnt_o, tx_data_o, tx_seq_o);
        end
        tx_ready_i = 1'b1;
        step();
        tx_ready_i = 1'b0;
        checks++;
        if (tx_data_o !== 9'h056 || tx_seq_o !== 8'd2) begin
            errors++;
            $display("FAIL chg_second: got d=%h s=%0d, want d=056 s=2", tx_data_o, tx_seq_o);
        end
`else
        checks++;
        if (level_o !== 4'd3 || drop_cnt_o !== 8'd0 || tx_data_o !== 9'h055 || tx_seq_o !== 8'd0) begin
            errors++;
            $display("FAIL nochg_first: got l=%0d dc=%0d d=%h s=%0d, want l=3 dc=0 d=055 s=0",
                     level_o, drop_cnt_o, tx_data_o, tx_seq_o);
        end
        tx_ready_i = 1'b1;
        step();
        tx_ready_i = 1'b0;
        checks++;
        if (tx_data_o !== 9'h055 || tx_seq_o !== 8'd1) begin
            errors++;
            $display("FAIL nochg_second: got d=%h s=%0d, want d=055 s=1", tx_data_o, tx_seq_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_freeze();
        test_overflow();
        test_full_pop();
        test_wrap_and_reset();
        test_change_only();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
